// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
// Shares the two register-file write ports between NUM_REQ functional units.
// Each unit pushes (addr,data) results into a private DEPTH-entry FIFO. A
// round-robin scheduler drains up to two FIFO heads per cycle: the first
// non-empty head in scan order goes to port 0, and the next non-empty head
// whose address differs from port 0 goes to port 1. Results to R0 are accepted
// and dropped.
//
// Optional feature macro: WB_STATS_EN
//   defined   : o_stall_cnt is a saturating count of cycles in which some
//               non-empty head was left ungranted.
//   undefined : o_stall_cnt is tied to zero.
//
// Ports
//   i_clk        system clock, all state updates on posedge
//   i_rst        synchronous active-high reset
//   i_req_valid  per-unit result valid
//   i_req_addr   per-unit destination register, unit i at [i*ADDR_W +: ADDR_W]
//   i_req_data   per-unit result, unit i at [i*DATA_W +: DATA_W]
//   o_req_ready  per-unit FIFO not full (low while i_rst is high)
//   o_wp0_*      write port 0 enable / register index / data (registered)
//   o_wp1_*      write port 1 enable / register index / data (registered)
//   o_busy       any FIFO non-empty
//   o_stall_cnt  saturating conflict counter (see WB_STATS_EN)
// -----------------------------------------------------------------------------
module wb_port_arbiter #(
   parameter int NUM_REQ = 6,
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 5,
   parameter int DEPTH   = 2
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic [NUM_REQ-1:0]          i_req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0]   i_req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]   i_req_data,
   output logic [NUM_REQ-1:0]          o_req_ready,
   output logic                        o_wp0_en,
   output logic [ADDR_W-1:0]           o_wp0_addr,
   output logic [DATA_W-1:0]           o_wp0_data,
   output logic                        o_wp1_en,
   output logic [ADDR_W-1:0]           o_wp1_addr,
   output logic [DATA_W-1:0]           o_wp1_data,
   output logic                        o_busy,
   output logic [15:0]                 o_stall_cnt
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int RR_W  = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0] w_ne;
   logic [NUM_REQ-1:0] w_full;
   logic [NUM_REQ-1:0] w_push;
   logic [NUM_REQ-1:0] w_pop;
   logic [ADDR_W-1:0]  w_head_addr [NUM_REQ];
   logic [DATA_W-1:0]  w_head_data [NUM_REQ];

   logic               w_g0_vld;
   logic               w_g1_vld;
   logic [RR_W-1:0]    w_g0_idx;
   logic [RR_W-1:0]    w_g1_idx;
   logic [RR_W-1:0]    w_rr_nxt;
   logic               w_stall;

   logic [RR_W-1:0]    r_rr;
   logic               r_wp0_en;
   logic [ADDR_W-1:0]  r_wp0_addr;
   logic [DATA_W-1:0]  r_wp0_data;
   logic               r_wp1_en;
   logic [ADDR_W-1:0]  r_wp1_addr;
   logic [DATA_W-1:0]  r_wp1_data;

   // Per-requester FIFOs
   for (genvar g = 0; g < NUM_REQ; g++) begin : g_fifo
      logic [ADDR_W-1:0] r_fa [DEPTH];
      logic [DATA_W-1:0] r_fd [DEPTH];
      logic [PTR_W-1:0]  r_wp;
      logic [PTR_W-1:0]  r_rp;
      logic [CNT_W-1:0]  r_cnt;
      logic [ADDR_W-1:0] w_in_addr;

      assign w_in_addr      = i_req_addr[g*ADDR_W +: ADDR_W];
      assign w_ne[g]        = (r_cnt != {CNT_W{1'b0}});
      assign w_full[g]      = (r_cnt == CNT_W'(DEPTH));
      // R0 writes are handshaken but never stored.
      assign w_push[g]      = i_req_valid[g] & ~w_full[g] & (w_in_addr != {ADDR_W{1'b0}});
      assign w_head_addr[g] = r_fa[r_rp];
      assign w_head_data[g] = r_fd[r_rp];

      // Entry storage; contents are qualified by the count, so no reset needed
      always_ff @(posedge i_clk) begin
         if (w_push[g]) begin
            r_fa[r_wp] <= w_in_addr;
            r_fd[r_wp] <= i_req_data[g*DATA_W +: DATA_W];
         end
      end

      // Pointer and occupancy update
      always_ff @(posedge i_clk) begin
         if (i_rst) begin
            r_wp  <= {PTR_W{1'b0}};
            r_rp  <= {PTR_W{1'b0}};
            r_cnt <= {CNT_W{1'b0}};
         end else begin
            if (w_push[g]) r_wp <= r_wp + PTR_W'(1);
            else           r_wp <= r_wp;
            if (w_pop[g])  r_rp <= r_rp + PTR_W'(1);
            else           r_rp <= r_rp;
            case ({w_push[g], w_pop[g]})
               2'b10:   r_cnt <= r_cnt + CNT_W'(1);
               2'b01:   r_cnt <= r_cnt - CNT_W'(1);
               default: r_cnt <= r_cnt;
            endcase
         end
      end
   end

   assign o_req_ready = ~w_full & {NUM_REQ{~i_rst}};
   assign o_busy      = |w_ne;

   // Round-robin scan: first head to port 0, next distinct-address head to port 1
   always_comb begin
      int               v_sum;
      logic [RR_W-1:0]  v_idx;
      w_g0_vld = 1'b0;
      w_g1_vld = 1'b0;
      w_g0_idx = {RR_W{1'b0}};
      w_g1_idx = {RR_W{1'b0}};
      w_stall  = 1'b0;
      w_pop    = {NUM_REQ{1'b0}};
      w_rr_nxt = r_rr;
      v_sum    = 0;
      v_idx    = {RR_W{1'b0}};
      for (int k = 0; k < NUM_REQ; k++) begin
         v_sum = int'(r_rr) + k;
         if (v_sum >= NUM_REQ) v_sum = v_sum - NUM_REQ;
         else                  v_sum = v_sum;
         v_idx = RR_W'(v_sum);
         if (w_ne[v_idx]) begin
            if (!w_g0_vld) begin
               w_g0_vld = 1'b1;
               w_g0_idx = v_idx;
            end else if (!w_g1_vld && (w_head_addr[v_idx] != w_head_addr[w_g0_idx])) begin
               w_g1_vld = 1'b1;
               w_g1_idx = v_idx;
            end else begin
               // Same-address or third head: keeps its place for a later cycle.
               w_stall = 1'b1;
            end
         end else begin
            w_stall = w_stall;
         end
      end
      if (w_g0_vld) w_pop[w_g0_idx] = 1'b1;
      else          w_pop = w_pop;
      if (w_g1_vld) w_pop[w_g1_idx] = 1'b1;
      else          w_pop = w_pop;
      // Port 1 is always later in scan order, so it is the last grant when present.
      if (w_g1_vld) begin
         if (w_g1_idx == RR_W'(NUM_REQ - 1)) w_rr_nxt = {RR_W{1'b0}};
         else                                w_rr_nxt = w_g1_idx + RR_W'(1);
      end else if (w_g0_vld) begin
         if (w_g0_idx == RR_W'(NUM_REQ - 1)) w_rr_nxt = {RR_W{1'b0}};
         else                                w_rr_nxt = w_g0_idx + RR_W'(1);
      end else begin
         w_rr_nxt = r_rr;
      end
   end

   // Write-port registers and round-robin pointer
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rr       <= {RR_W{1'b0}};
         r_wp0_en   <= 1'b0;
         r_wp0_addr <= {ADDR_W{1'b0}};
         r_wp0_data <= {DATA_W{1'b0}};
         r_wp1_en   <= 1'b0;
         r_wp1_addr <= {ADDR_W{1'b0}};
         r_wp1_data <= {DATA_W{1'b0}};
      end else begin
         r_rr     <= w_rr_nxt;
         r_wp0_en <= w_g0_vld;
         r_wp1_en <= w_g1_vld;
         if (w_g0_vld) begin
            r_wp0_addr <= w_head_addr[w_g0_idx];
            r_wp0_data <= w_head_data[w_g0_idx];
         end else begin
            r_wp0_addr <= r_wp0_addr;
            r_wp0_data <= r_wp0_data;
         end
         if (w_g1_vld) begin
            r_wp1_addr <= w_head_addr[w_g1_idx];
            r_wp1_data <= w_head_data[w_g1_idx];
         end else begin
            r_wp1_addr <= r_wp1_addr;
            r_wp1_data <= r_wp1_data;
         end
      end
   end

   assign o_wp0_en   = r_wp0_en;
   assign o_wp0_addr = r_wp0_addr;
   assign o_wp0_data = r_wp0_data;
   assign o_wp1_en   = r_wp1_en;
   assign o_wp1_addr = r_wp1_addr;
   assign o_wp1_data = r_wp1_data;

`ifdef WB_STATS_EN
   logic [15:0] r_stall_cnt;

   // Saturating count of cycles with an ungranted non-empty head
   always_ff @(posedge i_clk) begin
      if (i_rst)                                    r_stall_cnt <= 16'd0;
      else if (w_stall && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 16'd1;
      else                                          r_stall_cnt <= r_stall_cnt;
   end

   assign o_stall_cnt = r_stall_cnt;
`else
   logic w_unused_stall;
   assign w_unused_stall = w_stall;
   assign o_stall_cnt    = 16'd0;
`endif

endmodule
